// File: rtl/fpu_pkg.sv
// fpu_pkg -- shared encodings for the rounding pipeline.
//   * rnd_mode_e : rounding-mode codes carried on rnd_mode (codes 5-7 behave as RNE)
//   * FLAG_*     : bit positions inside the 4-bit flags word {overflow, underflow, inexact, zero}
package fpu_pkg;

    typedef enum logic [2:0] {
        RND_RNE = 3'd0,   // round to nearest, ties to even
        RND_RTZ = 3'd1,   // round toward zero
        RND_RDN = 3'd2,   // round toward -infinity
        RND_RUP = 3'd3,   // round toward +infinity
        RND_RMM = 3'd4    // round to nearest, ties away from zero
    } rnd_mode_e;

    localparam int FLAGS_W   = 4;
    localparam int FLAG_OV   = 3;
    localparam int FLAG_UF   = 2;
    localparam int FLAG_NX   = 1;
    localparam int FLAG_ZERO = 0;

endpackage

// File: rtl/round_pipe_if.sv
// round_pipe_if -- handshake and data bundle of the rounding pipeline.
//   Input side : in_valid/in_ready, sign, exponent[EXP_W], mantissa[DATA_W+3] (G,R,S in [2:0]),
//                rnd_mode[3]
//   Output side: out_valid/out_ready, sign_rnd, exponent_rnd[EXP_W], mantissa_rnd[DATA_W],
//                flags[4] = {overflow, underflow, inexact, zero}
//   master : the producer/consumer environment around the pipeline
//   slave  : the pipeline itself
interface round_pipe_if #(
    parameter int DATA_W = 24,
    parameter int EXP_W  = 8
);
    logic              in_valid;
    logic              in_ready;
    logic              sign;
    logic [EXP_W-1:0]  exponent;
    logic [DATA_W+2:0] mantissa;
    logic [2:0]        rnd_mode;

    logic              out_valid;
    logic              out_ready;
    logic              sign_rnd;
    logic [EXP_W-1:0]  exponent_rnd;
    logic [DATA_W-1:0] mantissa_rnd;
    logic [3:0]        flags;

    modport master (
        output in_valid, sign, exponent, mantissa, rnd_mode, out_ready,
        input  in_ready, out_valid, sign_rnd, exponent_rnd, mantissa_rnd, flags
    );

    modport slave (
        input  in_valid, sign, exponent, mantissa, rnd_mode, out_ready,
        output in_ready, out_valid, sign_rnd, exponent_rnd, mantissa_rnd, flags
    );
endinterface

// File: rtl/clz.sv
// clz -- combinational leading-zero counter.
//   data_i [DATA_W]      : value to scan
//   cnt_o  [CNT_W]       : number of zeros above the most significant one; DATA_W when data_i is 0
module clz #(
    parameter  int DATA_W = 24,
    localparam int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic [DATA_W-1:0] data_i,
    output logic [CNT_W-1:0]  cnt_o
);

    // Scan upward so the highest set bit is the last one to write the count.
    always_comb begin
        cnt_o = CNT_W'(DATA_W);
        for (int i = 0; i < DATA_W; i++) begin
            if (data_i[i]) begin
                cnt_o = CNT_W'(DATA_W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/round_pipe.sv
// round_pipe -- two-stage rounding and normalising pipeline with valid/ready handshakes.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears all valid, data and flag registers
//   bus   : round_pipe_if.slave (input operand + rnd_mode, rounded result + flags)
// S1 registers the rounded (DATA_W+1)-bit mantissa with its carry; S2 normalises with a single
// clz, applies overflow/underflow saturation and drives the output registers.
// Build option: define ROUND_PIPE_FLAGS_EN to compute and pipeline the flags word; otherwise
// flags is tied to 0 while saturation stays active.
module round_pipe #(
    parameter int DATA_W = 24,
    parameter int EXP_W  = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    round_pipe_if.slave  bus
);
    import fpu_pkg::*;

    localparam int EXT_W = EXP_W + 1;
    localparam int LZC_W = $clog2(DATA_W + 1);
    localparam logic [EXT_W-1:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

    function automatic logic round_up(input logic [2:0] mode, input logic sgn,
                                      input logic l, input logic g, input logic r, input logic s);
        logic any;
        any = g | r | s;
        case (mode)
            RND_RTZ: round_up = 1'b0;
            RND_RDN: round_up = sgn & any;
            RND_RUP: round_up = ~sgn & any;
            RND_RMM: round_up = g;
            default: round_up = g & (r | s | l);
        endcase
    endfunction

    function automatic logic exp_saturates(input logic [EXT_W-1:0] e);
        return e >= EXP_MAX;
    endfunction

    // Control
    logic rdy_q;
    logic vld_p1_q, vld_p2_q;
    logic acc_p0, adv_p1, s2_free;

    // S1 state
    logic              sign_p1_q;
    logic [EXP_W-1:0]  exp_p1_q;
    logic [DATA_W:0]   mant_p1_q, mant_p1_d;
    logic              up_p0;

    // S2 state
    logic              sign_p2_q;
    logic [EXP_W-1:0]  exp_p2_q, exp_p2_d;
    logic [DATA_W-1:0] mant_p2_q, mant_p2_d;
    logic [DATA_W-1:0] frac_p1;
    logic [LZC_W-1:0]  lzc_p1;
    logic [EXT_W-1:0]  exp_ext_p1, exp_n_p1;
    logic              ovf_p1, unf_p1, zero_p1;

    // S2 can take a new item when empty or when its current item leaves this cycle.
    assign s2_free      = ~vld_p2_q | bus.out_ready;
    assign adv_p1       = vld_p1_q & s2_free;
    // rdy_q keeps in_ready low under reset and releases it on the first clock afterwards.
    assign bus.in_ready = rdy_q & (~vld_p1_q | s2_free);
    assign acc_p0       = bus.in_valid & bus.in_ready;

    assign up_p0     = round_up(bus.rnd_mode, bus.sign, bus.mantissa[3],
                                bus.mantissa[2], bus.mantissa[1], bus.mantissa[0]);
    assign mant_p1_d = {1'b0, bus.mantissa[DATA_W+2:3]} + {{DATA_W{1'b0}}, up_p0};

    // ---- S1: round decision folded into an incremented mantissa, carry kept ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q     <= 1'b0;
            vld_p1_q  <= 1'b0;
            sign_p1_q <= 1'b0;
            exp_p1_q  <= '0;
            mant_p1_q <= '0;
        end else begin
            rdy_q <= 1'b1;
            if (acc_p0) begin
                vld_p1_q  <= 1'b1;
                sign_p1_q <= bus.sign;
                exp_p1_q  <= bus.exponent;
                mant_p1_q <= mant_p1_d;
            end else if (adv_p1) begin
                vld_p1_q <= 1'b0;
            end
        end
    end

    assign frac_p1    = mant_p1_q[DATA_W-1:0];
    assign exp_ext_p1 = {1'b0, exp_p1_q};

    clz #(.DATA_W(DATA_W)) u_clz (
        .data_i (frac_p1),
        .cnt_o  (lzc_p1)
    );

    // Normalisation: a carry can only come from an all-ones mantissa, so shifting right by one
    // leaves the leading one in place. Otherwise shift left by lzc, or by the exponent alone
    // when lzc would take it below zero.
    always_comb begin
        ovf_p1    = 1'b0;
        unf_p1    = 1'b0;
        zero_p1   = 1'b0;
        exp_n_p1  = '0;
        mant_p2_d = '0;
        if (mant_p1_q == '0) begin
            zero_p1 = 1'b1;
        end else if (mant_p1_q[DATA_W]) begin
            exp_n_p1  = exp_ext_p1 + EXT_W'(1);
            mant_p2_d = mant_p1_q[DATA_W:1];
        end else if (EXT_W'(lzc_p1) > exp_ext_p1) begin
            unf_p1    = 1'b1;
            mant_p2_d = frac_p1 << exp_p1_q;
        end else begin
            exp_n_p1  = exp_ext_p1 - EXT_W'(lzc_p1);
            mant_p2_d = frac_p1 << lzc_p1;
        end
        if (!zero_p1 && !unf_p1 && exp_saturates(exp_n_p1)) begin
            ovf_p1    = 1'b1;
            exp_n_p1  = EXP_MAX;
            mant_p2_d = '0;
        end
        exp_p2_d = exp_n_p1[EXP_W-1:0];
    end

    // ---- S2: normalised, saturated result registers ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2_q  <= 1'b0;
            sign_p2_q <= 1'b0;
            exp_p2_q  <= '0;
            mant_p2_q <= '0;
        end else begin
            if (adv_p1) begin
                vld_p2_q  <= 1'b1;
                sign_p2_q <= sign_p1_q;
                exp_p2_q  <= exp_p2_d;
                mant_p2_q <= mant_p2_d;
            end else if (bus.out_ready) begin
                vld_p2_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid    = vld_p2_q;
    assign bus.sign_rnd     = sign_p2_q;
    assign bus.exponent_rnd = exp_p2_q;
    assign bus.mantissa_rnd = mant_p2_q;

`ifdef ROUND_PIPE_FLAGS_EN
    logic               nx_p1_q;
    logic [FLAGS_W-1:0] flags_p2_q, flags_p2_d;

    // ---- S1: inexact travels with the rounded mantissa ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nx_p1_q <= 1'b0;
        end else if (acc_p0) begin
            nx_p1_q <= |bus.mantissa[2:0];
        end
    end

    always_comb begin
        flags_p2_d            = '0;
        flags_p2_d[FLAG_OV]   = ovf_p1;
        flags_p2_d[FLAG_UF]   = unf_p1;
        flags_p2_d[FLAG_NX]   = nx_p1_q;
        flags_p2_d[FLAG_ZERO] = zero_p1;
    end

    // ---- S2: flags register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_p2_q <= '0;
        end else if (adv_p1) begin
            flags_p2_q <= flags_p2_d;
        end
    end

    assign bus.flags = flags_p2_q;
`else
    assign bus.flags = '0;
`endif

endmodule

// File: doc/round_pipe.md
ROUND_PIPE -- requirements
Module: round_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 24, meaning the rounded mantissa width including the leading one.
REQ-002 SHALL have parameter EXP_W, default 8, meaning the exponent width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state SHALL be on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1 bit, and in_ready, output, 1 bit: the input handshake.
REQ-006 SHALL have port sign, input, 1 bit: the operand sign, used by directed modes.
REQ-007 SHALL have port exponent, input, EXP_W bits: the unbiased-by-block exponent.
REQ-008 SHALL have port mantissa, input, DATA_W+3 bits: the mantissa with guard, round and sticky in bits [2:0].
REQ-009 SHALL have port rnd_mode, input, 3 bits: the rounding mode, sampled with the data.
REQ-010 SHALL have port out_valid, output, 1 bit, and out_ready, input, 1 bit: the output handshake.
REQ-011 SHALL have port sign_rnd, output, 1 bit; exponent_rnd, output, EXP_W bits; mantissa_rnd, output, DATA_W bits.
REQ-012 SHALL have port flags, output, 4 bits: {overflow, underflow, inexact, zero}.

Function
REQ-013 Transfer SHALL occur on valid&ready; 2-stage pipeline, latency 2 cycles, throughput 1/cycle with no bubbles while out_ready=1.
REQ-014 Stage S1 SHALL register the round decision and a (DATA_W+1)-bit incremented mantissa (carry kept).
REQ-015 Stage S2 SHALL normalise: on carry, shift right 1 and add 1 to exponent; otherwise shift left by lzc and subtract lzc from exponent.
REQ-016 With G,R,S = mantissa[2:0] and L = mantissa[3], round-up SHALL be: RNE (0): G&(R|S|L); RTZ (1): 0; RDN (2): sign&(G|R|S); RUP (3): ~sign&(G|R|S); RMM (4): G; codes 5-7: RNE.
REQ-017 Exponent arithmetic SHALL use EXP_W+1 bits internally.
REQ-018 Overflow: if the normalised exponent is at or above all-ones, outputs SHALL be exponent all-ones and mantissa 0, with overflow set.
REQ-019 Underflow: if lzc > exponent, the output SHALL be exponent 0 and mantissa shifted left by exponent only, with underflow set.
REQ-020 A zero rounded mantissa SHALL give exponent 0, mantissa 0, zero=1, and underflow=0.
REQ-021 inexact SHALL equal G|R|S of the input.
REQ-022 Stall: a stage SHALL hold its contents when the downstream stage is full and not accepting.
REQ-023 in_ready SHALL be ~S1_full | S1 advancing; in_ready SHALL not depend combinationally on in_valid.
REQ-024 Accept and emit in the same cycle SHALL preserve order, with no loss and no duplication.

Reset
REQ-025 While rst_n=0, all valid bits SHALL be 0 and all data and flags registers SHALL be 0.
REQ-026 Outputs under reset SHALL be: out_valid=0, in_ready=0, data and flags 0.
REQ-027 in_ready SHALL be 1 from the first clock after rst_n rises.
REQ-028 Reset mid-operation SHALL discard in-flight items.

Configuration
REQ-029 Macro ROUND_PIPE_FLAGS_EN defined: flags SHALL be computed and pipelined as specified.
REQ-030 Macro ROUND_PIPE_FLAGS_EN undefined: flags SHALL be tied to 0 and no flag logic or registers synthesised.
REQ-031 With ROUND_PIPE_FLAGS_EN undefined, overflow and underflow saturation per REQ-018/019 SHALL remain active.

Structure
REQ-032 Package fpu_pkg SHALL hold the rnd_mode encodings (RNE, RTZ, RDN, RUP, RMM) and the flag bit indices.
REQ-033 Leading-zero count SHALL use the existing clz sub-module (DATA_W parameter), instantiated once in S2.

Verification (DATA_W=24, EXP_W=8)
REQ-034 RNE tie, even: mantissa {24'h800000,3'b100}, exp 8'h80 -> 24'h800000, exp 8'h80, inexact=1, out_valid 2 cycles later.
REQ-035 RNE tie, odd: {24'h800001,3'b100} -> 24'h800002.
REQ-036 Carry: {24'hFFFFFF,3'b100}, exp 8'h7F, RNE -> 24'h800000, exp 8'h80.
REQ-037 Overflow: {24'hFFFFFF,3'b111}, exp 8'hFE -> exp 8'hFF, mantissa 0, flags overflow and inexact.
REQ-038 Directed modes: {24'h800000,3'b001}, sign=1 -> RDN 24'h800001; RUP and RTZ 24'h800000; inexact=1.
REQ-039 Normalise: {24'h000F00,3'b000}, exp 8'h20 -> 24'hF00000, exp 8'h14, flags 0.
REQ-040 Backpressure: 4 back-to-back inputs with out_ready=0 for 5 cycles -> in_ready drops after 2 items held; all 4 emerge in order, no duplicates.
REQ-041 Reset mid-operation: rst_n low while out_valid=1 -> out_valid 0 immediately; in_ready=1 one clock after release.
